note_match_multilane: RTL

//  Per-lane note matcher for all fret lanes. Each lane holds the nearest past and next future

---
 rtl/note_match_multilane.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/note_match_multilane.sv
// Per-lane chart note matcher: each fret lane tracks its nearest past and future note, grades
// presses by timing error, reports unplayed notes as misses and merges events into one stream.
module note_match_multilane #(
   parameter int  LANES       = 5,
   parameter int  TW          = 16,
   parameter int  TIMEOUT     = 100,
   parameter int  PERFECT_WIN = 3,
   parameter int  GOOD_WIN    = 8,
   localparam int LW          = (LANES > 1) ? $clog2(LANES) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [TW-1:0]       song_time,
   input  logic [LANES-1:0]    note_edge,
   input  logic [LANES*TW-1:0] note_time,
   input  logic [LANES-1:0]    note_valid,
   output logic [LANES-1:0]    note_request,
   output logic                evt_valid,
   output logic [LW-1:0]       evt_lane,
   output logic [2:0]          evt_type,
   output logic [TW-1:0]       evt_time,
   output logic [TW-1:0]       evt_delta,
   output logic [7:0]          drop_cnt
);

   localparam logic [2:0] EV_MISS    = 3'd0;
   localparam logic [2:0] EV_STRAY   = 3'd1;
   localparam logic [2:0] EV_BAD     = 3'd2;
   localparam logic [2:0] EV_GOOD    = 3'd3;
   localparam logic [2:0] EV_PERFECT = 3'd4;

   function automatic logic [2:0] grade(input logic [TW-1:0] delta);
      logic [2:0] g;
      if (delta <= TW'(PERFECT_WIN)) begin
         g = EV_PERFECT;
      end else if (delta <= TW'(GOOD_WIN)) begin
         g = EV_GOOD;
      end else begin
         g = EV_BAD;
      end
      return g;
   endfunction

   logic [LANES-1:0] past_valid_r, fut_valid_r, fut_matched_r, awaiting_r;
   logic [TW-1:0]    past_time_r [LANES];
   logic [TW-1:0]    fut_time_r  [LANES];
   logic [LANES-1:0] hit_full_r, miss_full_r;
   logic [2:0]       hit_type_r  [LANES];
   logic [TW-1:0]    hit_time_r  [LANES];
   logic [TW-1:0]    hit_delta_r [LANES];
   logic [TW-1:0]    miss_time_r [LANES];

   logic [LANES-1:0] cand_s, req_s, shift_s, pick_past_s, pick_fut_s, timeout_s, miss_load_s;
   logic [LANES-1:0] drain_hit_s, drain_miss_s;
   logic [TW-1:0]    dp_s [LANES];
   logic [TW-1:0]    df_s [LANES];
   logic [2:0]       hit_type_s  [LANES];
   logic [TW-1:0]    hit_time_s  [LANES];
   logic [TW-1:0]    hit_delta_s [LANES];
   logic             gnt_valid_s, gnt_hit_s;
   logic [LW-1:0]    gnt_lane_s;
   logic [2:0]       gnt_type_s;
   logic [TW-1:0]    gnt_time_s, gnt_delta_s;
   logic [7:0]       drop_inc_s;
   logic [8:0]       drop_sum_s;

   // Requests are suppressed while reset is held so the buffers never pop during reset
   assign note_request = req_s & {LANES{~rst}};

   // Per-lane fetch, match selection, grading and miss detection from registered state
   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         dp_s[i]        = song_time - past_time_r[i];
         df_s[i]        = fut_time_r[i] - song_time;
         cand_s[i]      = fut_valid_r[i] & ~fut_matched_r[i] & (fut_time_r[i] >= song_time);
         req_s[i]       = ~awaiting_r[i] & (~fut_valid_r[i] | (fut_time_r[i] < song_time));
         shift_s[i]     = req_s[i] & fut_valid_r[i];
         pick_past_s[i] = note_edge[i] & past_valid_r[i] & (~cand_s[i] | (dp_s[i] <= df_s[i]));
         pick_fut_s[i]  = note_edge[i] & cand_s[i] & ~pick_past_s[i];
         timeout_s[i]   = past_valid_r[i] & ~note_edge[i] & (dp_s[i] > TW'(TIMEOUT));
         // a past note consumed by this cycle's press is never reported as missed
         miss_load_s[i] = past_valid_r[i] & ~pick_past_s[i] & (shift_s[i] | timeout_s[i]);
         if (pick_past_s[i]) begin
            hit_type_s[i]  = grade(dp_s[i]);
            hit_time_s[i]  = past_time_r[i];
            hit_delta_s[i] = dp_s[i];
         end else if (pick_fut_s[i]) begin
            hit_type_s[i]  = grade(df_s[i]);
            hit_time_s[i]  = fut_time_r[i];
            hit_delta_s[i] = df_s[i];
         end else begin
            hit_type_s[i]  = EV_STRAY;
            hit_time_s[i]  = song_time;
            hit_delta_s[i] = {TW{1'b0}};
         end
      end
   end

   // Fixed-priority arbiter: lowest lane first, hit slot ahead of miss slot
   always_comb begin
      gnt_valid_s = 1'b0;
      gnt_hit_s   = 1'b0;
      gnt_lane_s  = {LW{1'b0}};
      gnt_type_s  = EV_MISS;
      gnt_time_s  = {TW{1'b0}};
      gnt_delta_s = {TW{1'b0}};
      for (int i = LANES - 1; i >= 0; i--) begin
         if (hit_full_r[i]) begin
            gnt_valid_s = 1'b1;
            gnt_hit_s   = 1'b1;
            gnt_lane_s  = LW'(i);
            gnt_type_s  = hit_type_r[i];
            gnt_time_s  = hit_time_r[i];
            gnt_delta_s = hit_delta_r[i];
         end else if (miss_full_r[i]) begin
            gnt_valid_s = 1'b1;
            gnt_hit_s   = 1'b0;
            gnt_lane_s  = LW'(i);
            gnt_type_s  = EV_MISS;
            gnt_time_s  = miss_time_r[i];
            gnt_delta_s = {TW{1'b0}};
         end else begin
            gnt_valid_s = gnt_valid_s;
         end
      end
      for (int i = 0; i < LANES; i++) begin
         drain_hit_s[i]  = gnt_valid_s & gnt_hit_s & (gnt_lane_s == LW'(i));
         drain_miss_s[i] = gnt_valid_s & ~gnt_hit_s & (gnt_lane_s == LW'(i));
      end
   end

   // Count slot overwrites this cycle; a slot being drained can be reloaded without loss
   always_comb begin
      drop_inc_s = 8'd0;
      for (int i = 0; i < LANES; i++) begin
         drop_inc_s = drop_inc_s + {7'd0, note_edge[i] & hit_full_r[i] & ~drain_hit_s[i]}
                                 + {7'd0, miss_load_s[i] & miss_full_r[i] & ~drain_miss_s[i]};
      end
      drop_sum_s = {1'b0, drop_cnt} + {1'b0, drop_inc_s};
   end

   // Per-lane note window: fetch, shift, match consumption and timeout
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         past_valid_r  <= {LANES{1'b0}};
         fut_valid_r   <= {LANES{1'b0}};
         fut_matched_r <= {LANES{1'b0}};
         awaiting_r    <= {LANES{1'b0}};
         for (int i = 0; i < LANES; i++) begin
            past_time_r[i] <= {TW{1'b0}};
            fut_time_r[i]  <= {TW{1'b0}};
         end
      end else begin
         for (int i = 0; i < LANES; i++) begin
            awaiting_r[i] <= req_s[i];
            if (awaiting_r[i]) begin
               fut_time_r[i]    <= note_time[i*TW +: TW];
               fut_valid_r[i]   <= note_valid[i];
               fut_matched_r[i] <= 1'b0;
            end else if (pick_fut_s[i]) begin
               fut_matched_r[i] <= 1'b1;
            end
            if (shift_s[i]) begin
               past_time_r[i]  <= fut_time_r[i];
               past_valid_r[i] <= ~(fut_matched_r[i] | pick_fut_s[i]);
            end else if (pick_past_s[i] | timeout_s[i]) begin
               past_valid_r[i] <= 1'b0;
            end
         end
      end
   end

   // Per-lane hit and miss event slots
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hit_full_r  <= {LANES{1'b0}};
         miss_full_r <= {LANES{1'b0}};
         for (int i = 0; i < LANES; i++) begin
            hit_type_r[i]  <= EV_MISS;
            hit_time_r[i]  <= {TW{1'b0}};
            hit_delta_r[i] <= {TW{1'b0}};
            miss_time_r[i] <= {TW{1'b0}};
         end
      end else begin
         for (int i = 0; i < LANES; i++) begin
            if (note_edge[i]) begin
               hit_full_r[i]  <= 1'b1;
               hit_type_r[i]  <= hit_type_s[i];
               hit_time_r[i]  <= hit_time_s[i];
               hit_delta_r[i] <= hit_delta_s[i];
            end else if (drain_hit_s[i]) begin
               hit_full_r[i] <= 1'b0;
            end
            if (miss_load_s[i]) begin
               miss_full_r[i] <= 1'b1;
               miss_time_r[i] <= past_time_r[i];
            end else if (drain_miss_s[i]) begin
               miss_full_r[i] <= 1'b0;
            end
         end
      end
   end

   // Registered event stream and saturating drop counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         evt_valid <= 1'b0;
         evt_lane  <= {LW{1'b0}};
         evt_type  <= EV_MISS;
         evt_time  <= {TW{1'b0}};
         evt_delta <= {TW{1'b0}};
         drop_cnt  <= 8'd0;
      end else begin
         evt_valid <= gnt_valid_s;
         if (gnt_valid_s) begin
            evt_lane  <= gnt_lane_s;
            evt_type  <= gnt_type_s;
            evt_time  <= gnt_time_s;
            evt_delta <= gnt_delta_s;
         end
         drop_cnt <= drop_sum_s[8] ? 8'hFF : drop_sum_s[7:0];
      end
   end

endmodule
